operand_select_pipe: RTL and testbench

Parametrised, registered N:1 operand/writeback selector with per-input divide-by-power-of-two scaling and a valid/ready skid-buffered output stage. It sits where the datapath chooses between ALU result, memory read data, immediate and PC-derived values, e.g. before the register-file write port or the ALU B operand. Scaling turns byte addresses into word indices. The two-entry skid buffer lets downstream stall without a combinational ready path back to the source.

---
 rtl/operand_select_pkg.sv | 18 +
 rtl/operand_select_core.sv | 34 +++
 rtl/operand_select_pipe.sv | 101 ++++++++++
 tb/tb_operand_select_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_select_pkg.sv
// rtl/operand_select_pkg.sv - shared types and constants for the operand select pipe
package operand_select_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } opsel_state_e;

    localparam int unsigned OPSEL_WIDTH = 32;
    localparam int unsigned OPSEL_SHIFT = 2;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_MEM = 1;
    localparam int unsigned SRC_IMM = 2;
    localparam int unsigned SRC_PC  = 3;

endpackage

// File: rtl/operand_select_core.sv
// rtl/operand_select_core.sv - combinational select, scale and range check producing {err, src, data}
module operand_select_core
    import operand_select_pkg::*;
#(
    parameter int unsigned            WIDTH      = OPSEL_WIDTH,
    parameter int unsigned            NUM_INPUTS = 4,
    parameter int unsigned            SEL_W      = $clog2(NUM_INPUTS),
    parameter int unsigned            SHIFT      = OPSEL_SHIFT,
    parameter logic [NUM_INPUTS-1:0]  SCALE_MASK = '0
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic [WIDTH+SEL_W:0]        item_o
);

    logic [WIDTH-1:0] data;
    logic             err;

    // Any selector value that matches no input falls through as an error with zero data.
    always_comb begin
        data = '0;
        err  = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_i == SEL_W'(i)) begin
                err  = 1'b0;
                data = SCALE_MASK[i] ? (in_data_i[i*WIDTH +: WIDTH] >> SHIFT)
                                     : in_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign item_o = {err, sel_i, data};

endmodule

// File: rtl/operand_select_pipe.sv
// rtl/operand_select_pipe.sv - registered N:1 operand selector with two-entry skid output stage
module operand_select_pipe
    import operand_select_pkg::*;
#(
    parameter int unsigned            WIDTH      = OPSEL_WIDTH,
    parameter int unsigned            NUM_INPUTS = 4,
    parameter int unsigned            SHIFT      = OPSEL_SHIFT,
    parameter logic [NUM_INPUTS-1:0]  SCALE_MASK = NUM_INPUTS'(4'b0010),
    localparam int unsigned           SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_src,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned ITEM_W = WIDTH + SEL_W + 1;

    opsel_state_e      state_q;
    logic [ITEM_W-1:0] main_q;
    logic [ITEM_W-1:0] skid_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [ITEM_W-1:0] item_d;
    logic              accept;
    logic              deliver;

    operand_select_core #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W),
        .SHIFT      (SHIFT),
        .SCALE_MASK (SCALE_MASK)
    ) u_core (
        .in_data_i (in_data),
        .sel_i     (in_sel),
        .item_o    (item_d)
    );

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid_q && out_ready;

    // in_ready is only ever low in TWO, so it is updated on the same edges that enter/leave TWO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= item_d;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_q <= item_d;
                    end else if (deliver) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        skid_q     <= item_d;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (deliver) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_err   = main_q[ITEM_W-1];
    assign out_src   = main_q[WIDTH +: SEL_W];
    assign out_data  = main_q[WIDTH-1:0];

endmodule

// File: tb/tb_operand_select_pipe.sv
// tb/tb_operand_select_pipe.sv - directed self-checking bench for operand_select_pipe
module tb_operand_select_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default instance: 4 inputs, 32 bits, input 1 scaled by 4
    logic [127:0] a_data;
    logic [1:0]   a_sel;
    logic         a_valid, a_ready, a_ovalid, a_oready, a_err;
    logic [31:0]  a_odata;
    logic [1:0]   a_src;

    operand_select_pipe dut_a (
        .clock(clk), .reset(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
        .in_ready(a_ready), .out_data(a_odata), .out_src(a_src), .out_err(a_err),
        .out_valid(a_ovalid), .out_ready(a_oready)
    );

    // Three-input instance for the out-of-range selector
    logic [95:0]  b_data;
    logic [1:0]   b_sel;
    logic         b_valid, b_ready, b_ovalid, b_oready, b_err;
    logic [31:0]  b_odata;
    logic [1:0]   b_src;

    operand_select_pipe #(.NUM_INPUTS(3)) dut_b (
        .clock(clk), .reset(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
        .in_ready(b_ready), .out_data(b_odata), .out_src(b_src), .out_err(b_err),
        .out_valid(b_ovalid), .out_ready(b_oready)
    );

    // Narrow instance with both inputs scaled by 8
    logic [31:0]  c_data;
    logic         c_sel;
    logic         c_valid, c_ready, c_ovalid, c_oready, c_err;
    logic [15:0]  c_odata;
    logic         c_src;

    operand_select_pipe #(.WIDTH(16), .NUM_INPUTS(2), .SHIFT(3), .SCALE_MASK(2'b11)) dut_c (
        .clock(clk), .reset(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
        .in_ready(c_ready), .out_data(c_odata), .out_src(c_src), .out_err(c_err),
        .out_valid(c_ovalid), .out_ready(c_oready)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   sel;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] D0 = {32'h0000_0100, 32'h0000_0020, 32'h0000_1000, 32'h0000_ABCD};
    localparam logic [127:0] D1 = {32'h0000_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0007};
    localparam logic [127:0] D2 = {32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        vecs[0] = '{D0, 2'd1, 32'h0000_0400};
        vecs[1] = '{D0, 2'd0, 32'h0000_ABCD};
        vecs[2] = '{D0, 2'd2, 32'h0000_0020};
        vecs[3] = '{D0, 2'd3, 32'h0000_0100};
        vecs[4] = '{D0, 2'd1, 32'h0000_0400};
        vecs[5] = '{D1, 2'd1, 32'h0000_0001};
        vecs[6] = '{D1, 2'd0, 32'h0000_0007};
        vecs[7] = '{D2, 2'd1, 32'h3FFF_FFFF};
        vecs[8] = '{D2, 2'd0, 32'hFFFF_FFFF};

        a_data = '0; a_sel = '0; a_valid = 1'b0; a_oready = 1'b1;
        b_data = '0; b_sel = '0; b_valid = 1'b0; b_oready = 1'b1;
        c_data = '0; c_sel = '0; c_valid = 1'b0; c_oready = 1'b1;

        step(); step();
        rst = 1'b0;
        step(); step();

        chk("reset_out_valid", 64'(a_ovalid), 64'd0);
        chk("reset_in_ready",  64'(a_ready),  64'd1);
        chk("reset_out_data",  64'(a_odata),  64'd0);
        chk("reset_out_src",   64'(a_src),    64'd0);
        chk("reset_out_err",   64'(a_err),    64'd0);

        // Streaming: one item per cycle, each visible right after its accept edge
        for (int i = 0; i < 9; i++) begin
            a_data  = vecs[i].data;
            a_sel   = vecs[i].sel;
            a_valid = 1'b1;
            step();
            chk($sformatf("stream_valid[%0d]", i), 64'(a_ovalid), 64'd1);
            chk($sformatf("stream_data[%0d]", i),  64'(a_odata),  64'(vecs[i].exp));
            chk($sformatf("stream_src[%0d]", i),   64'(a_src),    64'(vecs[i].sel));
            chk($sformatf("stream_ready[%0d]", i), 64'(a_ready),  64'd1);
            a_data = '1;
            a_sel  = 2'd1;
        end
        a_valid = 1'b0;
        step();
        chk("stream_drain_valid", 64'(a_ovalid), 64'd0);

        // Backpressure: third item must wait until in_ready returns
        a_data = D0; a_oready = 1'b0;
        a_sel = 2'd0; a_valid = 1'b1;
        step();
        a_sel = 2'd2;
        step();
        chk("bp_in_ready_low", 64'(a_ready),  64'd0);
        chk("bp_hold_data0",   64'(a_odata),  64'h0000_ABCD);
        a_sel = 2'd3;
        step();
        chk("bp_hold_data1",   64'(a_odata),  64'h0000_ABCD);
        chk("bp_hold_valid",   64'(a_ovalid), 64'd1);
        chk("bp_still_full",   64'(a_ready),  64'd0);
        a_oready = 1'b1;
        step();
        chk("bp_second_data",  64'(a_odata),  64'h0000_0020);
        chk("bp_ready_back",   64'(a_ready),  64'd1);
        step();
        chk("bp_third_data",   64'(a_odata),  64'h0000_0100);
        chk("bp_third_src",    64'(a_src),    64'd3);
        a_valid = 1'b0;
        step();
        chk("bp_empty",        64'(a_ovalid), 64'd0);

        // Reset while holding two items clears everything asynchronously
        a_oready = 1'b0; a_valid = 1'b1;
        a_sel = 2'd3;
        step();
        a_sel = 2'd1;
        step();
        chk("rst2_in_two", 64'(a_ready), 64'd0);
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst2_out_valid", 64'(a_ovalid), 64'd0);
        chk("rst2_in_ready",  64'(a_ready),  64'd1);
        chk("rst2_out_data",  64'(a_odata),  64'd0);
        chk("rst2_out_src",   64'(a_src),    64'd0);
        step();
        rst = 1'b0;
        a_oready = 1'b1; a_valid = 1'b1; a_sel = 2'd2;
        step();
        chk("rst2_new_item", 64'(a_odata), 64'h0000_0020);
        a_valid = 1'b0;
        step();
        chk("rst2_skid_gone", 64'(a_ovalid), 64'd0);

        // Out-of-range selector on the three-input instance
        b_data = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
        b_sel = 2'd3; b_valid = 1'b1;
        step();
        chk("err_flag", 64'(b_err),   64'd1);
        chk("err_data", 64'(b_odata), 64'd0);
        chk("err_src",  64'(b_src),   64'd3);
        chk("err_valid", 64'(b_ovalid), 64'd1);
        b_sel = 2'd2;
        step();
        chk("err_clear_flag", 64'(b_err),   64'd0);
        chk("err_clear_data", 64'(b_odata), 64'h33);
        b_sel = 2'd1;
        step();
        chk("err_b_scaled", 64'(b_odata), 64'h08);
        b_valid = 1'b0;

        // Narrow instance, both inputs scaled
        c_data = {16'h00FF, 16'h00FF}; c_sel = 1'b0; c_valid = 1'b1;
        step();
        chk("sweep_in0", 64'(c_odata), 64'h001F);
        c_sel = 1'b1;
        step();
        chk("sweep_in1", 64'(c_odata), 64'h001F);
        chk("sweep_src", 64'(c_src),   64'd1);
        c_data = {16'hFFFF, 16'h0100}; c_sel = 1'b0;
        step();
        chk("sweep_in0b", 64'(c_odata), 64'h0020);
        c_sel = 1'b1;
        step();
        chk("sweep_in1b", 64'(c_odata), 64'h1FFF);
        chk("sweep_err",  64'(c_err),   64'd0);
        c_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
